muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Iterative sequencer for RV32M multiply/divide ops (funct7 = MUL-extension, funct3 = mult_risc_funct3).
//  Sits beside the base ALU in EX: accepts one op via valid/ready, runs a shared radix-2 shift-add /
//  restoring-divide datapath for XLEN cycles, applies RISC-V sign/corner rules, returns result + rd tag.
// PARAMETERS
//  XLEN      32   operand/result width
//  TAG_W     5    destination-register tag width
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req_valid    in   1      op offered
//  req_ready    out  1      unit can accept (IDLE && !flush)
//  req_funct3   in   3      mult_risc_funct3: MUL/MULH/MULSU/MULU/DIV/DIVU/REM/REMU
//  req_rs1      in   XLEN   operand A (multiplicand / dividend)
//  req_rs2      in   XLEN   operand B (multiplier / divisor)
//  req_rd       in   TAG_W  destination tag, echoed on response
//  flush        in   1      pipeline kill; aborts in-flight op, no response
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer takes result
//  rsp_result   out  XLEN   result
//  rsp_rd       out  TAG_W  echoed tag
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, rsp_valid=0, rsp_result=0, rsp_rd=0, busy=0, count=0;
//   req_ready=1 once IDLE with flush low. Reset mid-op discards op, no response.
//  FSM: IDLE -> PREP -> CALC -> FIXUP -> DONE -> IDLE.
//   IDLE : accept on req_valid && req_ready; latch funct3, rs1, rs2, rd.
//   PREP : 1 cycle. Take |A|,|B| per signedness (MULH/DIV/REM: both signed; MULSU: A signed, B unsigned;
//          MULU/DIVU/REMU/MUL: unsigned); record result-sign. Divide-by-zero or signed overflow
//          (A=0x8000_0000, B=all-ones, DIV/REM) -> FIXUP directly with forced result.
//   CALC : exactly XLEN cycles, count 0..XLEN-1, one iteration/cycle; -> FIXUP when count==XLEN-1.
//   FIXUP: 1 cycle; negate if result-sign; select field; register rsp_result/rsp_rd; -> DONE.
//   DONE : rsp_valid=1; result/rd held stable while !rsp_ready; rsp_ready -> IDLE next cycle.
//  Latency: accept edge T; rsp_valid first high at T+XLEN+3 (35 for XLEN=32); corner cases T+3.
//  No overlap: req_ready=0 in every non-IDLE state incl. DONE; one op in flight.
//  Results: MUL low XLEN of product; MULH/MULSU/MULU high XLEN; DIV/DIVU quotient truncated toward 0;
//   REM/REMU remainder, sign follows dividend. Product register 2*XLEN bits; divide uses XLEN+1-bit
//   partial remainder.
//  Corners: B=0 -> DIV/DIVU all-ones, REM/REMU = A. Overflow -> DIV = 0x8000_0000, REM = 0.
//  flush: any state -> IDLE next edge, rsp_valid low next cycle, no response; flush in IDLE with
//   req_valid -> not accepted. flush wins over rsp_ready in DONE (response dropped).
//  Illegal: none; all 8 funct3 codes valid.
// STRUCTURE
//  Package enumerations: existing mult_risc_funct3 reused; add md_state_t enum
//   (IDLE, PREP, CALC, FIXUP, DONE) and MD_LATENCY = XLEN+3 constant.
//  Sub-module md_iter_step: combinational one-iteration datapath (add-shift for mul, trial-subtract/
//   restore for div) on {acc, operand}; controller owns registers, counter ($clog2(XLEN) bits), FSM.
// TESTING
//  1 MUL/MULH/MULU A=B=0xFFFF_FFFF -> 0x0000_0001 / 0x0000_0000 / 0xFFFF_FFFE; rsp_valid at T+35.
//  2 DIV/REM A=0x8000_0000 B=0xFFFF_FFFF -> 0x8000_0000 / 0x0000_0000, rsp_valid at T+3.
//  3 DIVU/REMU A=7 B=0 -> 0xFFFF_FFFF / 0x0000_0007; DIV A=0xFFFF_FFF9 B=2 -> 0xFFFF_FFFD, REM -> 0xFFFF_FFFF.
//  4 MULSU A=0xFFFF_FFFF B=2 -> 0xFFFF_FFFF; rsp_rd echoes req_rd=5'd17.
//  5 rsp_ready low 20 cycles in DONE -> rsp_valid/result/rd stable, req_ready=0; release -> IDLE, req_ready=1.
//  6 flush at CALC count=10 -> IDLE next cycle, no rsp_valid; flush+req_valid in IDLE -> not accepted;
//    rst_n low mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// Provides the operand/tag widths, the RV32M funct3 encoding, the controller
// state enum, and the accept-to-response latency of a full-length operation.
package muldiv_seq_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int CNT_W      = $clog2(XLEN);
  localparam int MD_LATENCY = XLEN + 3;

  // RV32M funct3 field; bit 2 separates the divide group from the multiply group
  typedef enum logic [2:0] {
    F3_MUL   = 3'd0,
    F3_MULH  = 3'd1,
    F3_MULSU = 3'd2,
    F3_MULU  = 3'd3,
    F3_DIV   = 3'd4,
    F3_DIVU  = 3'd5,
    F3_REM   = 3'd6,
    F3_REMU  = 3'd7
  } mult_risc_funct3;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIXUP,
    DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Ports:
//   req_valid/req_ready      request handshake
//   req_funct3, req_rs1/rs2  operation and operands
//   req_rd                   destination tag echoed as rsp_rd
//   flush                    pipeline kill
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_rd       response payload
//   busy                     unit is not idle
// Modports: master = issuing pipeline, slave = the sequencer.
interface muldiv_seq_ctrl_if;
  import muldiv_seq_ctrl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_rd;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_result;
  logic [TAG_W-1:0] rsp_rd;
  logic             busy;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_rd, busy
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_rd, busy
  );

endinterface

// File: rtl/muldiv_seq_ctrl_step.sv
// One radix-2 iteration of the shared multiply/divide datapath (combinational).
// Ports:
//   is_div        1 = restoring-divide step, 0 = shift-add multiply step
//   acc           upper half (product high / partial remainder)
//   operand       lower half (multiplier bits / dividend bits becoming quotient)
//   addend        multiplicand magnitude or divisor magnitude
//   acc_next, operand_next  state after this iteration
module md_iter_step
  import muldiv_seq_ctrl_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] operand,
  input  logic [XLEN-1:0] addend,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] operand_next
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_trial;

  // Multiply: conditionally add the multiplicand into the high half, then shift
  // {carry, acc, operand} right by one. Divide: shift {acc, operand} left by one
  // into an XLEN+1-bit partial remainder and keep the trial subtraction only
  // when it does not go negative; the quotient bit enters at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc};
    if (operand[0]) mul_sum = mul_sum + {1'b0, addend};
    div_shift = {acc, operand[XLEN-1]};
    div_trial = div_shift - {1'b0, addend};

    if (is_div) begin
      if (div_trial[XLEN]) begin
        acc_next     = div_shift[XLEN-1:0];
        operand_next = {operand[XLEN-2:0], 1'b0};
      end else begin
        acc_next     = div_trial[XLEN-1:0];
        operand_next = {operand[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_next     = mul_sum[XLEN:1];
      operand_next = {mul_sum[0], operand[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer placed beside the base ALU in EX.
// Accepts one op, works on operand magnitudes for XLEN cycles through
// md_iter_step, then restores the sign and returns the result with its rd tag.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          muldiv_seq_ctrl_if.slave (request, flush, response, busy)
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  muldiv_seq_ctrl_if.slave bus
);

  md_state_t        state_q;
  mult_risc_funct3  op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [XLEN-1:0]  acc_q, operand_q, addend_q, forced_q;
  logic [TAG_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             neg_q, corner_q;
  logic             rsp_valid_q, busy_q;
  logic [XLEN-1:0]  rsp_result_q;
  logic [TAG_W-1:0] rsp_rd_q;

  logic             is_div, is_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag, forced_val;
  logic [XLEN-1:0]  acc_next, operand_next;
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]  div_raw, div_fix, fix_result;

  assign bus.req_ready  = (state_q == IDLE) && !bus.flush;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_rd     = rsp_rd_q;
  assign bus.busy       = busy_q;

  // Operand preparation: magnitudes per signedness, result sign, and the two
  // divide corner cases that bypass iteration with a forced architectural result.
  always_comb begin
    is_div   = op_q[2];
    is_rem   = op_q[2] & op_q[1];
    a_neg    = (op_q inside {F3_MULH, F3_MULSU, F3_DIV, F3_REM}) && rs1_q[XLEN-1];
    b_neg    = (op_q inside {F3_MULH, F3_DIV, F3_REM}) && rs2_q[XLEN-1];
    a_mag    = a_neg ? (~rs1_q + 1'b1) : rs1_q;
    b_mag    = b_neg ? (~rs2_q + 1'b1) : rs2_q;
    div_zero = is_div && (rs2_q == '0);
    div_ovf  = (op_q inside {F3_DIV, F3_REM}) && (rs1_q == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_q == '1);
    if (div_zero)
      forced_val = is_rem ? rs1_q : '1;
    else
      forced_val = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  md_iter_step u_step (
    .is_div       (is_div),
    .acc          (acc_q),
    .operand      (operand_q),
    .addend       (addend_q),
    .acc_next     (acc_next),
    .operand_next (operand_next)
  );

  // Final sign correction and field selection: MUL keeps the low word, the
  // MULH group the high word; REM takes the remainder (sign of dividend).
  always_comb begin
    product     = {acc_q, operand_q};
    product_fix = neg_q ? (~product + 1'b1) : product;
    div_raw     = is_rem ? acc_q : operand_q;
    div_fix     = neg_q ? (~div_raw + 1'b1) : div_raw;
    if (corner_q)
      fix_result = forced_q;
    else if (is_div)
      fix_result = div_fix;
    else if (op_q == F3_MUL)
      fix_result = product_fix[XLEN-1:0];
    else
      fix_result = product_fix[2*XLEN-1:XLEN];
  end

  // Controller FSM with registered outputs. Flush has priority over everything
  // except reset, including a response waiting in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= F3_MUL;
      rs1_q        <= '0;
      rs2_q        <= '0;
      acc_q        <= '0;
      operand_q    <= '0;
      addend_q     <= '0;
      forced_q     <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      neg_q        <= 1'b0;
      corner_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_rd_q     <= '0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= mult_risc_funct3'(bus.req_funct3);
            rs1_q   <= bus.req_rs1;
            rs2_q   <= bus.req_rs2;
            rd_q    <= bus.req_rd;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          acc_q     <= '0;
          operand_q <= is_div ? a_mag : b_mag;
          addend_q  <= is_div ? b_mag : a_mag;
          neg_q     <= is_rem ? a_neg : (a_neg ^ b_neg);
          corner_q  <= div_zero || div_ovf;
          forced_q  <= forced_val;
          count_q   <= '0;
          state_q   <= (div_zero || div_ovf) ? FIXUP : CALC;
        end
        CALC: begin
          acc_q     <= acc_next;
          operand_q <= operand_next;
          count_q   <= count_q + 1'b1;
          if (count_q == CNT_W'(XLEN-1)) state_q <= FIXUP;
        end
        FIXUP: begin
          rsp_result_q <= fix_result;
          rsp_rd_q     <= rd_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed testbench for muldiv_seq_ctrl: RV32M results, corner cases,
// response back-pressure, flush and asynchronous reset behaviour.
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  muldiv_seq_ctrl_if ifc ();

  muldiv_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one request and returns just after the edge that accepts it.
  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_funct3 = f3;
    ifc.req_rs1    = a;
    ifc.req_rs2    = b;
    ifc.req_rd     = rd;
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
  endtask

  // Issues an op and waits for rsp_valid. Latency counts the accept edge as
  // edge 1, so a full op reports MD_LATENCY and a corner op reports 3.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, output logic [31:0] res,
                               output logic [4:0] rdo, output int lat);
    bit got;
    got = 0;
    startOp(f3, a, b, rd);
    lat = 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (ifc.rsp_valid) got = 1;
    end
    if (!got) checkOutput("rsp_valid timeout", 32'd0, 32'd1);
    res = ifc.rsp_result;
    rdo = ifc.rsp_rd;
  endtask

  // Accepts the pending response for one edge and checks the unit is free again.
  task automatic releaseResponse(input string tag);
    @(negedge clk);
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b0;
    checkOutput({tag, " rsp_valid after take"}, 32'(ifc.rsp_valid), 32'd0);
    checkOutput({tag, " req_ready after take"}, 32'(ifc.req_ready), 32'd1);
  endtask

  // Directed vectors: funct3, rs1, rs2, rd, expected result, expected latency
  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] res, held_res;
    logic [4:0]  rdo, held_rd;
    int          lat;
    bit          stable, seen;

    vecs.push_back('{"MUL -1*-1",    F3_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0001, MD_LATENCY});
    vecs.push_back('{"MULH -1*-1",   F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, MD_LATENCY});
    vecs.push_back('{"MULU max*max", F3_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MD_LATENCY});
    vecs.push_back('{"DIV ovf",      F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h8000_0000, 3});
    vecs.push_back('{"REM ovf",      F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 3});
    vecs.push_back('{"DIVU 7/0",     F3_DIVU,  32'd7,         32'd0,         5'd6,  32'hFFFF_FFFF, 3});
    vecs.push_back('{"REMU 7/0",     F3_REMU,  32'd7,         32'd0,         5'd7,  32'h0000_0007, 3});
    vecs.push_back('{"DIV -7/2",     F3_DIV,   32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, MD_LATENCY});
    vecs.push_back('{"REM -7/2",     F3_REM,   32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, MD_LATENCY});
    vecs.push_back('{"DIV 7/-2",     F3_DIV,   32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, MD_LATENCY});
    vecs.push_back('{"REM 7/-2",     F3_REM,   32'd7,         32'hFFFF_FFFE, 5'd12, 32'h0000_0001, MD_LATENCY});
    vecs.push_back('{"REM -8/0",     F3_REM,   32'hFFFF_FFF8, 32'd0,         5'd13, 32'hFFFF_FFF8, 3});
    vecs.push_back('{"DIVU 100/7",   F3_DIVU,  32'd100,       32'd7,         5'd14, 32'd14,        MD_LATENCY});
    vecs.push_back('{"MULSU -1*2",   F3_MULSU, 32'hFFFF_FFFF, 32'd2,         5'd17, 32'hFFFF_FFFF, MD_LATENCY});

    ifc.req_valid  = 1'b0;
    ifc.req_funct3 = 3'd0;
    ifc.req_rs1    = '0;
    ifc.req_rs2    = '0;
    ifc.req_rd     = '0;
    ifc.flush      = 1'b0;
    ifc.rsp_ready  = 1'b0;
    rst_n          = 1'b0;

    // Reset state
    #12;
    checkOutput("reset busy",       32'(ifc.busy), 32'd0);
    checkOutput("reset rsp_valid",  32'(ifc.rsp_valid), 32'd0);
    checkOutput("reset rsp_result", ifc.rsp_result, 32'd0);
    checkOutput("reset rsp_rd",     32'(ifc.rsp_rd), 32'd0);
    checkOutput("reset req_ready",  32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed result, tag and latency checks
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat);
      checkOutput({vecs[i].name, " result"},  res, vecs[i].exp);
      checkOutput({vecs[i].name, " rd"},      32'(rdo), 32'(vecs[i].rd));
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      checkOutput({vecs[i].name, " busy"},    32'(ifc.busy), 32'd1);
      releaseResponse(vecs[i].name);
    end

    // Back-pressure: 0x10000 * 0x30000 = 0x3_0000_0000, high word 3
    applyStimulus(F3_MULU, 32'h0001_0000, 32'h0003_0000, 5'd9, held_res, held_rd, lat);
    checkOutput("hold result", held_res, 32'd3);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_result !== held_res ||
          ifc.rsp_rd !== held_rd || ifc.req_ready !== 1'b0)
        stable = 0;
    end
    checkOutput("hold stable 20 cycles", 32'(stable), 32'd1);
    releaseResponse("hold");

    // Flush at CALC count=10 (accept edge + 11 edges)
    startOp(F3_DIVU, 32'd1000, 32'd3, 5'd20);
    repeat (11) @(posedge clk);
    #1 checkOutput("flush busy before", 32'(ifc.busy), 32'd1);
    @(negedge clk);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush busy after",      32'(ifc.busy), 32'd0);
    checkOutput("flush rsp_valid after", 32'(ifc.rsp_valid), 32'd0);
    @(negedge clk);
    ifc.flush = 1'b0;
    #1 checkOutput("flush req_ready idle", 32'(ifc.req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid) seen = 1;
    end
    checkOutput("flush no response", 32'(seen), 32'd0);

    // Flush with req_valid in IDLE must not accept
    @(negedge clk);
    ifc.flush      = 1'b1;
    ifc.req_valid  = 1'b1;
    ifc.req_funct3 = F3_MUL;
    #1 checkOutput("flush blocks req_ready", 32'(ifc.req_ready), 32'd0);
    @(posedge clk);
    #1 checkOutput("flush no accept busy", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    ifc.flush     = 1'b0;
    ifc.req_valid = 1'b0;
    #1 checkOutput("idle busy after flush req", 32'(ifc.busy), 32'd0);

    // Asynchronous reset in the middle of CALC
    startOp(F3_MUL, 32'd5, 32'd6, 5'd21);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset busy",       32'(ifc.busy), 32'd0);
    checkOutput("midreset rsp_valid",  32'(ifc.rsp_valid), 32'd0);
    checkOutput("midreset rsp_result", ifc.rsp_result, 32'd0);
    checkOutput("midreset rsp_rd",     32'(ifc.rsp_rd), 32'd0);
    checkOutput("midreset req_ready",  32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Unit operates normally after reset: 5*6 = 30
    applyStimulus(F3_MUL, 32'd5, 32'd6, 5'd22, res, rdo, lat);
    checkOutput("post-reset MUL result", res, 32'd30);
    checkOutput("post-reset MUL rd",     32'(rdo), 32'd22);
    releaseResponse("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
